seq_mag_compare: RTL

//  Multi-cycle, parametrised magnitude comparator, successor to the 4-bit cascadable LT/EQ/GT comparator.

---
 rtl/seq_mag_compare_if.sv | 37 +++
 rtl/seq_mag_compare.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_mag_compare_if.sv
// Purpose: handshake and operand/result bundle for seq_mag_compare.
//   Producer side: in_valid, in_ready, op_a, op_b, signed_mode, casc_lt/eq/gt
//   Consumer side: out_valid, out_ready, lt, eq, gt, out_slice
//   master : the environment (drives operands, accepts results)
//   slave  : the comparator
interface seq_mag_compare_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 4
);
   localparam int unsigned NSL = WIDTH / SLICE;
   localparam int unsigned SW  = $clog2(NSL + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             signed_mode;
   logic             casc_lt;
   logic             casc_eq;
   logic             casc_gt;
   logic             out_valid;
   logic             out_ready;
   logic             lt;
   logic             eq;
   logic             gt;
   logic [SW-1:0]    out_slice;

   modport master (
      output in_valid, op_a, op_b, signed_mode, casc_lt, casc_eq, casc_gt, out_ready,
      input  in_ready, out_valid, lt, eq, gt, out_slice
   );

   modport slave (
      input  in_valid, op_a, op_b, signed_mode, casc_lt, casc_eq, casc_gt, out_ready,
      output in_ready, out_valid, lt, eq, gt, out_slice
   );
endinterface

// File: rtl/seq_mag_compare.sv
// Purpose: multi-cycle magnitude comparator. Scans two WIDTH-bit operands
// MSB-first, SLICE bits per clock, stopping at the first differing slice.
// Optional two's-complement mode; falls back to registered cascade inputs
// when all slices are equal.
//   clk   : clock
//   rst   : synchronous reset, active-high (priority over flush)
//   flush : synchronous abort, returns to IDLE and discards any result
//   bus   : seq_mag_compare_if.slave (operand handshake in, result handshake out)
module seq_mag_compare #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   seq_mag_compare_if.slave   bus
);
   localparam int unsigned NSL = WIDTH / SLICE;
   localparam int unsigned SW  = $clog2(NSL + 1);
   localparam int unsigned KW  = (NSL > 1) ? $clog2(NSL) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sgn_q;
   logic             clt_q;
   logic             ceq_q;
   logic             cgt_q;
   logic [KW-1:0]    k_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             lt_q;
   logic             eq_q;
   logic             gt_q;
   logic [SW-1:0]    slice_q;

   // Decision for the slice currently under inspection
   int               shamt_c;
   logic [SLICE-1:0] a_sl_c;
   logic [SLICE-1:0] b_sl_c;
   logic             dec_c;
   logic             dlt_c;
   logic             deq_c;
   logic             dgt_c;
   logic [SW-1:0]    dslice_c;

   always_comb begin
      dec_c    = 1'b0;
      dlt_c    = 1'b0;
      deq_c    = 1'b0;
      dgt_c    = 1'b0;
      dslice_c = '0;
      // slice 0 is the most significant one
      shamt_c  = (int'(NSL) - 1 - int'(k_q)) * int'(SLICE);
      a_sl_c   = SLICE'(a_q >> shamt_c);
      b_sl_c   = SLICE'(b_q >> shamt_c);

      if (sgn_q && (k_q == '0) && (a_q[WIDTH-1] != b_q[WIDTH-1])) begin
         // differing signs: the non-negative operand is larger
         dec_c = 1'b1;
         dgt_c = ~a_q[WIDTH-1];
         dlt_c = a_q[WIDTH-1];
      end else if (a_sl_c != b_sl_c) begin
         dec_c    = 1'b1;
         dlt_c    = (a_sl_c < b_sl_c);
         dgt_c    = ~(a_sl_c < b_sl_c);
         dslice_c = SW'(int'(k_q) + 1);
      end else if (k_q == KW'(NSL - 1)) begin
         // operands equal: defer to the lower-significance stage
         dec_c    = 1'b1;
         dslice_c = SW'(NSL);
         if (ceq_q)               deq_c = 1'b1;
         else if (clt_q && !cgt_q) dlt_c = 1'b1;
         else if (cgt_q && !clt_q) dgt_c = 1'b1;
         else                      deq_c = 1'b1;
      end
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sgn_q       <= 1'b0;
         clt_q       <= 1'b0;
         ceq_q       <= 1'b0;
         cgt_q       <= 1'b0;
         k_q         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         lt_q        <= 1'b0;
         eq_q        <= 1'b0;
         gt_q        <= 1'b0;
         slice_q     <= '0;
      end else if (flush) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         lt_q        <= 1'b0;
         eq_q        <= 1'b0;
         gt_q        <= 1'b0;
         slice_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (bus.in_valid && in_ready_q) begin
                  a_q        <= bus.op_a;
                  b_q        <= bus.op_b;
                  sgn_q      <= bus.signed_mode;
                  clt_q      <= bus.casc_lt;
                  ceq_q      <= bus.casc_eq;
                  cgt_q      <= bus.casc_gt;
                  k_q        <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= SCAN;
               end
            end
            SCAN: begin
               if (dec_c) begin
                  out_valid_q <= 1'b1;
                  lt_q        <= dlt_c;
                  eq_q        <= deq_c;
                  gt_q        <= dgt_c;
                  slice_q     <= dslice_c;
                  state_q     <= DONE;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  lt_q        <= 1'b0;
                  eq_q        <= 1'b0;
                  gt_q        <= 1'b0;
                  slice_q     <= '0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.lt        = lt_q;
   assign bus.eq        = eq_q;
   assign bus.gt        = gt_q;
   assign bus.out_slice = slice_q;

endmodule
